// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte
// producers. One byte is in flight at a time. A byte with req_last=0 locks the
// transmitter to its owner until the owner sends a byte with req_last=1, or
// until the owner idles for HOLD_MAX cycles. A watchdog aborts a transfer
// whose tx_done never arrives.
//
// Ports:
//   clk, RST        single clock, synchronous active-low reset
//   req_valid/data/last  per-requester byte offer (byte k in req_data[8k+7:8k])
//   req_ready       one-hot single-cycle accept pulse
//   tx_start/tx_data/tx_enable  drive the transmitter
//   tx_busy, tx_done           transmitter status (tx_done is a 1-cycle pulse)
//   grant_id        current or last owner
//   sched_busy      high whenever the scheduler is not idle
//   err             sticky: [0] done timeout, [1] hold dropped; err_clr clears
module uart_tx_sched #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 2604,
  parameter int DONE_TIMEOUT = 12*CLKS_PER_BIT,
  parameter int HOLD_MAX     = 1024,
  localparam int GW          = $clog2(NUM_REQ)
)(
  input  logic                 clk,
  input  logic                 RST,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic                 tx_enable,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic [GW-1:0]        grant_id,
  output logic                 sched_busy,
  output logic [1:0]           err,
  input  logic                 err_clr
);

  localparam int WW = $clog2(DONE_TIMEOUT+1);
  localparam int HW = $clog2(HOLD_MAX+1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_HOLD, S_ABORT} state_t;

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [WW-1:0] wdog;
  logic [HW-1:0] hcnt;
  logic          last_q;

  logic          win_found;
  logic [GW-1:0] win_id;
  logic [GW:0]   scan_sum;
  logic [GW-1:0] scan_idx;

  function automatic logic [GW-1:0] next_id(input logic [GW-1:0] id);
    return (int'(id) == NUM_REQ-1) ? '0 : id + 1'b1;
  endfunction

  // Scan from the highest offset down so the requester closest to rr_ptr
  // (lowest offset, wrapping) is the last assignment and therefore wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      scan_sum = {1'b0, rr_ptr} + (GW+1)'(i);
      if (scan_sum >= (GW+1)'(NUM_REQ)) scan_sum = scan_sum - (GW+1)'(NUM_REQ);
      scan_idx = scan_sum[GW-1:0];
      if (req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      req_ready  <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      tx_enable  <= 1'b0;
      grant_id   <= '0;
      sched_busy <= 1'b0;
      err        <= '0;
      wdog       <= '0;
      hcnt       <= '0;
      last_q     <= 1'b0;
    end else begin
      req_ready <= '0;
      tx_start  <= 1'b0;
      tx_enable <= 1'b1;
      // Clear first; a set later in this block overrides it.
      if (err_clr) err <= '0;
      unique case (state)
        S_IDLE: begin
          if (win_found) begin
            grant_id          <= win_id;
            tx_data           <= req_data[{win_id, 3'b000} +: 8];
            last_q            <= req_last[win_id];
            tx_start          <= 1'b1;
            req_ready[win_id] <= 1'b1;
            sched_busy        <= 1'b1;
            state             <= S_START;
          end
        end
        S_START: begin
          wdog  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // tx_done is tested first so it beats a same-cycle timeout.
          if (tx_done) begin
            if (last_q) begin
              rr_ptr     <= next_id(grant_id);
              sched_busy <= 1'b0;
              state      <= S_IDLE;
            end else begin
              hcnt  <= '0;
              state <= S_HOLD;
            end
          end else if (wdog == WW'(DONE_TIMEOUT-1)) begin
            err[0]    <= 1'b1;
            rr_ptr    <= next_id(grant_id);
            tx_enable <= 1'b0;
            state     <= S_ABORT;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        S_HOLD: begin
          if (req_valid[grant_id]) begin
            tx_data             <= req_data[{grant_id, 3'b000} +: 8];
            last_q              <= req_last[grant_id];
            tx_start            <= 1'b1;
            req_ready[grant_id] <= 1'b1;
            state               <= S_START;
          end else if (hcnt == HW'(HOLD_MAX-1)) begin
            err[1]     <= 1'b1;
            rr_ptr     <= next_id(grant_id);
            sched_busy <= 1'b0;
            state      <= S_IDLE;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        S_ABORT: begin
          sched_busy <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // The transmitter can only be busy while a transfer is owned by us.
  a_busy_owned: assert property (@(posedge clk) disable iff (!RST) tx_busy |-> sched_busy);
  a_start_pulse: assert property (@(posedge clk) disable iff (!RST) tx_start |=> !tx_start);
  // A timeout shorter than one bit time could never be met.
  a_cfg: assert property (@(posedge clk) DONE_TIMEOUT > CLKS_PER_BIT);
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;
  localparam int N   = 4;
  localparam int CPB = 4;
  localparam int DT  = 20;
  localparam int HM  = 16;

  logic           clk = 1'b0;
  logic           RST;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic           tx_start, tx_enable, tx_busy, tx_done, sched_busy, err_clr;
  logic [7:0]     tx_data;
  logic [1:0]     grant_id, err;

  always #5 clk = ~clk;

  uart_tx_sched #(.NUM_REQ(N), .CLKS_PER_BIT(CPB), .DONE_TIMEOUT(DT), .HOLD_MAX(HM)) dut (
    .clk(clk), .RST(RST), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_enable(tx_enable),
    .tx_busy(tx_busy), .tx_done(tx_done), .grant_id(grant_id), .sched_busy(sched_busy),
    .err(err), .err_clr(err_clr)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester message queues (circular, bit 8 = last).
  logic [8:0] qm [N][256];
  int hd[N], tl[N], gap[N];

  // Transaction-level reference model.
  typedef enum int {P_FREE, P_START, P_BUSY, P_LOCK, P_ABORT} phase_t;
  phase_t     phase = P_FREE;
  int         ptr = 0, win = 0, start_cyc = 0, done_at = -1, hidle = 0, cyc = 0;
  bit         last_cur = 1'b0;
  logic [1:0] m_err = 2'b00;
  int         m_gid = 0;
  bit         exp_ok = 0, exp_start = 0, exp_en = 0, exp_busy = 0, exp_rst = 0;

  // Knobs.
  bit rst_drv = 0, no_done = 0;
  int done_min = 1, done_max = 6, gap_max = 0, clr_pct = 0, wd_pct = 0;

  int dlog[$];  // grant_id observed at each DUT tx_start

  function automatic int pick(logic [N-1:0] v, int p);
    for (int i = 0; i < N; i++) if (v[(p+i)%N]) return (p+i)%N;
    return 0;
  endfunction

  task automatic push(int k, logic [7:0] d, bit l);
    qm[k][tl[k] & 255] = {l, d};
    tl[k]++;
  endtask

  task automatic flush();
    for (int k = 0; k < N; k++) begin hd[k] = tl[k]; gap[k] = 0; end
  endtask

  task automatic step();
    logic [N-1:0] v;
    logic [1:0]   set;
    @(posedge clk); #1;
    cyc++;
    // Drive this cycle's inputs.
    for (int k = 0; k < N; k++) begin
      v[k] = rst_drv && (hd[k] != tl[k]) && (gap[k] == 0);
      if (gap[k] > 0) gap[k]--;
      req_data[8*k +: 8] = (hd[k] != tl[k]) ? qm[k][hd[k] & 255][7:0] : 8'h00;
      req_last[k]        = (hd[k] != tl[k]) ? qm[k][hd[k] & 255][8]   : 1'b0;
    end
    req_valid = v;
    tx_done   = rst_drv && (phase == P_BUSY) && (cyc == done_at);
    tx_busy   = (phase == P_BUSY);
    err_clr   = ($urandom_range(0, 99) < clr_pct);
    RST       = rst_drv;
    // Compare this cycle's outputs with the model's prediction.
    if (tx_start === 1'b1) dlog.push_back(int'(grant_id));
    if (exp_ok) begin
      chk("tx_start", tx_start, exp_start);
      chk("req_ready", req_ready, exp_start ? (32'd1 << win) : 32'd0);
      chk("tx_enable", tx_enable, exp_en);
      chk("sched_busy", sched_busy, exp_busy);
      chk("err", err, m_err);
      chk("grant_id", grant_id, m_gid);
      if (exp_start) chk("tx_data", tx_data, qm[win][hd[win] & 255][7:0]);
      if (exp_rst)   chk("tx_data_rst", tx_data, 0);
    end
    // Handshake completes in the START cycle: pop the owner's byte.
    if (exp_start) begin
      last_cur = qm[win][hd[win] & 255][8];
      hd[win]++;
      gap[win] = $urandom_range(0, gap_max);
    end
    // Advance the model to next cycle.
    exp_start = 0;
    set = 2'b00;
    if (!rst_drv) begin
      phase = P_FREE; ptr = 0; m_gid = 0; m_err = 2'b00; exp_rst = 1;
    end else begin
      exp_rst = 0;
      case (phase)
        P_FREE: if (|v) begin
          win = pick(v, ptr); m_gid = win; exp_start = 1; phase = P_START;
        end
        P_START: begin
          phase = P_BUSY; start_cyc = cyc;
          done_at = (no_done || ($urandom_range(0, 99) < wd_pct)) ? -1
                    : cyc + $urandom_range(done_min, done_max);
        end
        P_BUSY: begin
          if (tx_done) begin
            if (last_cur) begin phase = P_FREE; ptr = (win+1)%N; end
            else begin phase = P_LOCK; hidle = 0; end
          end else if (cyc - start_cyc == DT) begin
            set[0] = 1'b1; ptr = (win+1)%N; phase = P_ABORT;
          end
        end
        P_LOCK: begin
          if (v[win]) begin exp_start = 1; phase = P_START; end
          else begin
            hidle++;
            if (hidle == HM) begin set[1] = 1'b1; ptr = (win+1)%N; phase = P_FREE; end
          end
        end
        default: phase = P_FREE;
      endcase
      m_err = (err_clr ? 2'b00 : m_err) | set;
    end
    exp_en   = rst_drv && (phase != P_ABORT);
    exp_busy = rst_drv && (phase != P_FREE);
    exp_ok   = 1;
  endtask

  task automatic drain(int max);
    int  n;
    bit  pend;
    n = 0;
    do begin
      step(); n++;
      pend = (phase != P_FREE);
      for (int k = 0; k < N; k++) if (hd[k] != tl[k]) pend = 1;
    end while (pend && n < max);
    chk("drain", pend, 0);
  endtask

  task automatic chk_log(string tag, input int e[$]);
    chk($sformatf("%s_cnt", tag), dlog.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), (i < dlog.size()) ? dlog[i] : 99, e[i]);
  endtask

  task automatic rand_phase(int iters);
    int k, len;
    for (int i = 0; i < iters; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, N-1);
        if (tl[k] - hd[k] < 4) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) push(k, 8'($urandom), b == len-1);
        end
      end
      step();
    end
  endtask

  initial begin
    int eq[$];
    int n;
    RST = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    tx_done = 1'b0; tx_busy = 1'b0; err_clr = 1'b0;
    for (int k = 0; k < N; k++) begin hd[k] = 0; tl[k] = 0; gap[k] = 0; end

    // Reset values.
    repeat (3) step();
    rst_drv = 1;

    // Single byte from requester 2.
    dlog.delete();
    push(2, 8'hA5, 1);
    drain(60);
    eq = '{2}; chk_log("single", eq);

    // Round robin: priority now starts at 3.
    dlog.delete();
    for (int r = 0; r < 2; r++) for (int k = 0; k < N; k++) push(k, 8'(16*k + r), 1);
    drain(200);
    eq = '{3, 0, 1, 2, 3, 0, 1, 2}; chk_log("rr", eq);

    // Locked message from requester 1 while requester 0 waits.
    dlog.delete();
    push(1, 8'h11, 0); push(1, 8'h22, 0); push(1, 8'h33, 1);
    step();
    push(0, 8'h5C, 1);
    drain(200);
    eq = '{1, 1, 1, 0}; chk_log("lock", eq);

    // Hold drop: requester 3 opens a message then goes silent.
    dlog.delete();
    push(3, 8'h7E, 0);
    drain(100);
    step();
    chk("hold_err", err, 2'b10);
    push(0, 8'h01, 1); push(1, 8'h02, 1);
    drain(100);
    eq = '{3, 0, 1}; chk_log("drop", eq);
    clr_pct = 100; step(); clr_pct = 0; step();
    chk("err_clr1", err, 2'b00);

    // Watchdog: transmitter never answers.
    no_done = 1;
    push(2, 8'h3C, 1);
    drain(100);
    no_done = 0;
    step();
    chk("wd_err", err, 2'b01);
    clr_pct = 100; step(); clr_pct = 0; step();
    chk("err_clr0", err, 2'b00);

    // Reset while waiting for tx_done.
    no_done = 1;
    push(1, 8'h99, 1);
    n = 0;
    while (phase != P_BUSY && n < 10) begin step(); n++; end
    step();
    chk("mid_wait_busy", sched_busy, 1);
    flush(); rst_drv = 0;
    step(); step();
    rst_drv = 1; no_done = 0;
    repeat (8) step();

    // Randomized traffic with gaps, clears and occasional hung transfers.
    gap_max = 3; clr_pct = 5; wd_pct = 4; done_min = 1; done_max = 8;
    rand_phase(600);
    clr_pct = 0; wd_pct = 0;
    drain(600);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: got time %0t expected finish", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one `UART_Transmitter` instance between up to `NUM_REQ` byte producers, such as the APB write path and GPIO event reporting. It accepts one byte at a time from the winning requester and drives `TX_start`/`data_byte`. It then waits for `TX_done` before granting again. It supports atomic multi-byte messages through a per-requester `last` flag, and runs a watchdog that aborts a hung transfer.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `CLKS_PER_BIT`, default 2604: must match the transmitter's value.
- `DONE_TIMEOUT`, default 12*`CLKS_PER_BIT`: cycles allowed from `tx_start` to `tx_done`.
- `HOLD_MAX`, default 1024: cycles a locked owner may idle before its lock is dropped.

Ports:
- `clk`, in, 1: system clock. There is one clock; all logic is on its rising edge.
- `RST`, in, 1: reset, synchronous and active-low.
- `req_valid`, in, `NUM_REQ`: per-requester byte-valid.
- `req_data`, in, 8*`NUM_REQ`: byte k occupies bits [8k+7:8k].
- `req_last`, in, `NUM_REQ`: 1 marks the final byte of a message.
- `req_ready`, out, `NUM_REQ`: one-hot, one-cycle accept pulse.
- `tx_start`, out, 1: connects to transmitter `TX_start`.
- `tx_data`, out, 8: connects to `data_byte`.
- `tx_enable`, out, 1: connects to `enable`.
- `tx_busy`, in, 1: from `TX_busy`. Status only.
- `tx_done`, in, 1: from `TX_done`. One-cycle pulse.
- `grant_id`, out, clog2(`NUM_REQ`): index of the current or last owner.
- `sched_busy`, out, 1: high in every state except IDLE.
- `err`, out, 2: sticky. Bit 0 is done-timeout; bit 1 is hold-dropped.
- `err_clr`, in, 1: clears `err`.

## Operation
State machine states are IDLE, START, WAIT, HOLD and ABORT.
- **IDLE**
  - If any `req_valid` is high, pick the winner by round-robin and go to START.
  - Round-robin search begins at `rr_ptr` and wraps from `NUM_REQ`-1 to 0.
  - The winner's `req_data` and `req_last` are registered on the same edge, and `grant_id` is updated.
- **START** (exactly 1 cycle)
  - `tx_start`=1 and `req_ready[grant_id]`=1. `tx_data` holds the registered byte.
  - Load the watchdog counter with 0, then go to WAIT.
- **WAIT**
  - Increment the watchdog every cycle.
  - On `tx_done`:
    - if the latched `last`=1: set `rr_ptr`=`grant_id`+1 (modulo `NUM_REQ`) and go to IDLE;
    - otherwise go to HOLD.
  - If the watchdog reaches `DONE_TIMEOUT` before `tx_done`: set `err[0]`, advance `rr_ptr` past the owner, and go to ABORT.
  - If `tx_done` and the timeout occur in the same cycle, `tx_done` wins.
- **HOLD**
  - The lock belongs to `grant_id` only; other requesters are ignored.
  - If the owner's `req_valid` is high, latch its byte and `last`, then go to START.
  - The hold counter counts idle cycles. At `HOLD_MAX`: set `err[1]`, advance `rr_ptr` past the owner, and go to IDLE.
- **ABORT** (1 cycle)
  - `tx_enable`=0 to reset the transmitter, then go to IDLE.
- **`tx_enable`**: 1 in all states except ABORT and reset.
- **`err`**:
  - Bits set when their condition fires and are cleared by `err_clr`=1.
  - If a set and a clear happen in the same cycle, the set wins.
- **`tx_busy`**: ignored for sequencing and used only for `sched_busy` assertion checks.

## Timing
- **Reset values** (while `RST`=0 at an edge):
  - state IDLE, `rr_ptr`=0;
  - `req_ready`=0, `tx_start`=0, `tx_data`=0, `tx_enable`=0;
  - `grant_id`=0, `sched_busy`=0, `err`=0;
  - both counters cleared.
- Reset asserted mid-transfer returns the block to IDLE at that edge, and no `req_ready` is issued.
- **Latency:**
  - `req_valid` seen in IDLE in cycle N gives `tx_start` and `req_ready` in cycle N+1.
  - `tx_done` in cycle M with `last`=1 gives IDLE in cycle M+1. The earliest next `tx_start` is then M+2.
  - In HOLD, an owner valid in cycle H gives `tx_start` in H+1.
- **Handshake:** a byte transfers in the cycle where `req_valid`&`req_ready`.
  - The requester holds valid and data stable until `req_ready`.
  - The requester presents its next byte, or drops valid, in the following cycle.
- **Outputs:** all outputs are registered; there is no combinational path from inputs to outputs.
- **Pulse widths:** `req_ready` and `tx_start` are never high for more than 1 cycle, and are never high in consecutive cycles.

## Test plan
- **Single byte:**
  - Stimulus: requester 2 sends 0xA5 with last=1 from reset.
  - Response: `tx_start` one cycle later with `tx_data`=0xA5 and `req_ready`=4'b0100. After `tx_done`, the next priority starts at 3.
- **Round-robin fairness:**
  - Stimulus: all 4 requesters continuously valid with last=1.
  - Response: grant order 0,1,2,3,0, with one `tx_start` per `tx_done`.
- **Locked message:**
  - Stimulus: requester 1 sends 0x11 (last=0), 0x22 (last=0), 0x33 (last=1) while requester 0 stays valid.
  - Response: requester 0 is not granted until after 0x33's `tx_done`.
- **Hold drop:**
  - Stimulus: requester 3 sends 0x7E with last=0, then idles for `HOLD_MAX` cycles.
  - Response: `err[1]`=1, return to IDLE, and requester 0 is granted next.
- **Watchdog:**
  - Stimulus: `tx_done` held at 0 after `tx_start`.
  - Response: after `DONE_TIMEOUT` cycles, `err[0]`=1, `tx_enable`=0 for one cycle, then IDLE. `err_clr` returns `err` to 0.
- **Reset mid-WAIT:**
  - Stimulus: `RST`=0 during WAIT.
  - Response: all outputs take their reset values at the next edge, and there is no spurious `req_ready` after release.
